// File: rtl/walls_pkg.sv
// Shared definitions for the multi-wall renderer.
//   field_e    : register field selector carried in address_i[2:0]
//   wall_t     : one wall's bounds, colour and enable
//   WALL_IDX_W : width of a wall index (never below 1 bit)
// Wall bounds are held at WALL_CW bits; the top zero-extends narrower
// coordinate buses, so COORD_W may be at most WALL_CW.
package walls_pkg;

  localparam int unsigned WALL_CW = 32;

  typedef enum logic [2:0] {
    FLD_XMIN  = 3'd0,
    FLD_XMAX  = 3'd1,
    FLD_YMIN  = 3'd2,
    FLD_YMAX  = 3'd3,
    FLD_COLOR = 3'd4,
    FLD_EN    = 3'd5
  } field_e;

  typedef struct packed {
    logic [WALL_CW-1:0] x_min;
    logic [WALL_CW-1:0] x_max;
    logic [WALL_CW-1:0] y_min;
    logic [WALL_CW-1:0] y_max;
    logic [23:0]        colour;
    logic               en;
  } wall_t;

  function automatic int unsigned WALL_IDX_W(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/walls_controller_multi_wall_hit.sv
// Pure combinational hit test of one pixel against one wall.
//   wall_i : wall registers (active copy)
//   x_i/y_i: pixel coordinates, unsigned
//   hit_o  : enabled wall covers the pixel (half-open bounds)
// An inverted or degenerate rectangle can never satisfy both compares,
// so empty walls need no special handling.
module wall_hit
  import walls_pkg::*;
(
  input  wall_t              wall_i,
  input  logic [WALL_CW-1:0] x_i,
  input  logic [WALL_CW-1:0] y_i,
  output logic               hit_o
);

  assign hit_o = wall_i.en
               & (x_i >= wall_i.x_min) & (x_i < wall_i.x_max)
               & (y_i >= wall_i.y_min) & (y_i < wall_i.y_max);

endmodule

// File: rtl/walls_controller_multi.sv
// Multi-wall renderer with frame-synchronous shadow/active registers.
//   clk, rst          : clock, asynchronous active-high reset
//   MW_i, address_i,
//   data_i            : CPU write port, address = {wall index, field}
//   frame_start_i     : commits all shadow registers to active
//   pix_valid_i,
//   x_pos_i, y_pos_i  : pixel stream from the scan path
//   RGB_o, hit_o,
//   wall_id_o,
//   pix_valid_o       : result two cycles later, lowest wall index wins
module walls_controller_multi
  import walls_pkg::*;
#(
  parameter int unsigned NUM_WALLS = 4,
  parameter int unsigned COORD_W   = 32,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              MW_i,
  input  logic [$clog2(NUM_WALLS)+2:0]      address_i,
  input  logic [COORD_W-1:0]                data_i,
  input  logic                              frame_start_i,
  input  logic                              pix_valid_i,
  input  logic [COORD_W-1:0]                x_pos_i,
  input  logic [COORD_W-1:0]                y_pos_i,
  output logic [23:0]                       RGB_o,
  output logic                              hit_o,
  output logic [WALL_IDX_W(NUM_WALLS)-1:0]  wall_id_o,
  output logic                              pix_valid_o
);

  localparam int unsigned AW = $clog2(NUM_WALLS) + 3;
  localparam int unsigned IW = WALL_IDX_W(NUM_WALLS);

  wall_t [NUM_WALLS-1:0] shadow_q, shadow_d;
  wall_t [NUM_WALLS-1:0] active_q;

  logic [AW-1:0] wr_idx;
  field_e        wr_fld;

  assign wr_idx = address_i >> 3;
  assign wr_fld = field_e'(address_i[2:0]);

  // Indices >= NUM_WALLS never match a slot; reserved fields fall to default.
  always_comb begin
    shadow_d = shadow_q;
    if (MW_i) begin
      for (int unsigned i = 0; i < NUM_WALLS; i++) begin
        if (wr_idx == AW'(i)) begin
          case (wr_fld)
            FLD_XMIN:  shadow_d[i].x_min  = WALL_CW'(data_i);
            FLD_XMAX:  shadow_d[i].x_max  = WALL_CW'(data_i);
            FLD_YMIN:  shadow_d[i].y_min  = WALL_CW'(data_i);
            FLD_YMAX:  shadow_d[i].y_max  = WALL_CW'(data_i);
            FLD_COLOR: shadow_d[i].colour = data_i[23:0];
            FLD_EN:    shadow_d[i].en     = data_i[0];
            default:   ;
          endcase
        end
      end
    end
  end

  // Active loads the pre-edge shadow, so a same-cycle write waits a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (frame_start_i) active_q <= shadow_q;
    end
  end

  logic [WALL_CW-1:0]   x_ext, y_ext;
  logic [NUM_WALLS-1:0] hit_vec;

  assign x_ext = WALL_CW'(x_pos_i);
  assign y_ext = WALL_CW'(y_pos_i);

  for (genvar g = 0; g < NUM_WALLS; g++) begin : g_hit
    wall_hit u_hit (
      .wall_i (active_q[g]),
      .x_i    (x_ext),
      .y_i    (y_ext),
      .hit_o  (hit_vec[g])
    );
  end

  // Stage 1 also snapshots the colours so that a commit landing between
  // the stages cannot recolour a pixel already in flight.
  logic [NUM_WALLS-1:0]       hit_s1_q;
  logic [NUM_WALLS-1:0][23:0] col_s1_q;
  logic                       pv_s1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_s1_q <= '0;
      col_s1_q <= '0;
      pv_s1_q  <= 1'b0;
    end else begin
      hit_s1_q <= pix_valid_i ? hit_vec : '0;
      pv_s1_q  <= pix_valid_i;
      for (int unsigned i = 0; i < NUM_WALLS; i++) begin
        col_s1_q[i] <= active_q[i].colour;
      end
    end
  end

  logic [23:0]   rgb_d, rgb_q;
  logic          hit_d, hit_q;
  logic [IW-1:0] id_d, id_q;
  logic          pv_q;

  // Scan from the highest index down so the lowest set index is kept.
  always_comb begin
    rgb_d = BG_COLOR;
    hit_d = 1'b0;
    id_d  = '0;
    if (pv_s1_q) begin
      for (int unsigned i = NUM_WALLS; i > 0; i--) begin
        if (hit_s1_q[i-1]) begin
          rgb_d = col_s1_q[i-1];
          hit_d = 1'b1;
          id_d  = IW'(i - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= BG_COLOR;
      hit_q <= 1'b0;
      id_q  <= '0;
      pv_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hit_q <= hit_d;
      id_q  <= id_d;
      pv_q  <= pv_s1_q;
    end
  end

  assign RGB_o       = rgb_q;
  assign hit_o       = hit_q;
  assign wall_id_o   = id_q;
  assign pix_valid_o = pv_q;

endmodule

// File: tb/tb_walls_controller_multi.sv
module tb_walls_controller_multi;

  localparam int N = 5;
  localparam logic [23:0] BG = 24'h0A0B0C;

  typedef struct packed {
    bit        v;
    bit        hit;
    bit [2:0]  id;
    bit [23:0] rgb;
  } exp_t;

  typedef struct packed {
    bit [31:0] xmin, xmax, ymin, ymax;
    bit [23:0] col;
    bit        en;
  } mwall_t;

  localparam exp_t IDLE = '{v: 1'b0, hit: 1'b0, id: 3'd0, rgb: BG};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MW = 1'b0;
  logic [5:0]  address = '0;
  logic [31:0] data = '0;
  logic        fs = 1'b0;
  logic        pv = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic [23:0] RGB;
  logic        hit;
  logic [2:0]  wid;
  logic        pvo;

  walls_controller_multi #(.NUM_WALLS(N), .COORD_W(32), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .MW_i(MW), .address_i(address), .data_i(data),
    .frame_start_i(fs), .pix_valid_i(pv), .x_pos_i(x), .y_pos_i(y),
    .RGB_o(RGB), .hit_o(hit), .wall_id_o(wid), .pix_valid_o(pvo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  mwall_t sh[N];
  mwall_t ac[N];
  exp_t exp_mid = IDLE;
  exp_t exp_out = IDLE;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // The visible colour is the first enabled wall, by index, whose
  // half-open rectangle contains the pixel.
  function automatic exp_t predict(input bit v, input bit [31:0] px, input bit [31:0] py);
    exp_t e = IDLE;
    if (v) begin
      e.v = 1'b1;
      for (int w = 0; w < N; w++) begin
        if (!e.hit && ac[w].en && px >= ac[w].xmin && px < ac[w].xmax &&
            py >= ac[w].ymin && py < ac[w].ymax) begin
          e.hit = 1'b1;
          e.id  = 3'(w);
          e.rgb = ac[w].col;
        end
      end
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int w = 0; w < N; w++) begin
      sh[w] = '0;
      ac[w] = '0;
    end
    exp_mid = IDLE;
    exp_out = IDLE;
  endtask

  task automatic cycle(input bit mw, input bit [5:0] a, input bit [31:0] d,
                       input bit f, input bit v, input bit [31:0] px, input bit [31:0] py);
    exp_t   e;
    mwall_t nsh[N];
    int     idx;
    @(negedge clk);
    MW = mw; address = a; data = d; fs = f; pv = v; x = px; y = py;
    e = rst ? IDLE : predict(v, px, py);
    nsh = sh;
    idx = int'(a[5:3]);
    if (mw && idx < N) begin
      case (a[2:0])
        3'd0: nsh[idx].xmin = d;
        3'd1: nsh[idx].xmax = d;
        3'd2: nsh[idx].ymin = d;
        3'd3: nsh[idx].ymax = d;
        3'd4: nsh[idx].col  = d[23:0];
        3'd5: nsh[idx].en   = d[0];
        default: ;
      endcase
    end
    @(posedge clk);
    if (rst) begin
      exp_mid = IDLE;
      exp_out = IDLE;
    end else begin
      if (f) ac = sh;
      sh = nsh;
      exp_out = exp_mid;
      exp_mid = e;
    end
  endtask

  task automatic idle();
    cycle(0, 6'd0, 32'd0, 0, 0, 32'd0, 32'd0);
  endtask

  task automatic wr(input int idx, input int fld, input bit [31:0] d, input bit f = 0);
    bit [5:0] a;
    a = {3'(idx), 3'(fld)};
    cycle(1, a, d, f, 0, 32'd0, 32'd0);
  endtask

  task automatic commit();
    cycle(0, 6'd0, 32'd0, 1, 0, 32'd0, 32'd0);
  endtask

  task automatic write_wall(input int idx, input bit [31:0] x0, x1, y0, y1,
                            input bit [23:0] c, input bit en);
    wr(idx, 0, x0); wr(idx, 1, x1); wr(idx, 2, y0); wr(idx, 3, y1);
    wr(idx, 4, 32'(c)); wr(idx, 5, 32'(en));
  endtask

  // Issue one pixel between idle cycles and pin the result with literals.
  task automatic pix_check(input string nm, input bit [31:0] px, input bit [31:0] py,
                           input bit ehit, input bit [23:0] ergb, input bit [2:0] eid);
    cycle(0, 6'd0, 32'd0, 0, 1, px, py);
    #2 check({nm, "_early_pv"}, 32'(pvo), 32'd0);
    idle();
    #2;
    check({nm, "_pv"},  32'(pvo), 32'd1);
    check({nm, "_hit"}, 32'(hit), 32'(ehit));
    check({nm, "_rgb"}, 32'(RGB), 32'(ergb));
    check({nm, "_id"},  32'(wid), 32'(eid));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_pv"},  32'(pvo), 32'd0);
    check({nm, "_hit"}, 32'(hit), 32'd0);
    check({nm, "_rgb"}, 32'(RGB), 32'(BG));
    check({nm, "_id"},  32'(wid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; MW = 1'b0; fs = 1'b0; pv = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_clear();
    idle();
    idle();
    #2 rst = 1'b0;
  endtask

  // Every cycle, the outputs must equal the model's result for the pixel
  // presented two edges earlier.
  always @(posedge clk) begin
    #1;
    check("stream_pv",  32'(pvo), 32'(exp_out.v));
    check("stream_hit", 32'(hit), 32'(exp_out.hit));
    check("stream_rgb", 32'(RGB), 32'(exp_out.rgb));
    check("stream_id",  32'(wid), 32'(exp_out.id));
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    #1 rst = 1'b0;

    pix_check("bg_pixel", 32'd30, 32'd40, 0, BG, 3'd0);

    write_wall(0, 32'd22, 32'd60, 32'd35, 32'd200, 24'h15688E, 1);
    pix_check("uncommitted", 32'd30, 32'd40, 0, BG, 3'd0);
    commit();
    pix_check("committed", 32'd30, 32'd40, 1, 24'h15688E, 3'd0);

    pix_check("b_22_35",  32'd22, 32'd35,  1, 24'h15688E, 3'd0);
    pix_check("b_60_35",  32'd60, 32'd35,  0, BG,         3'd0);
    pix_check("b_21_35",  32'd21, 32'd35,  0, BG,         3'd0);
    pix_check("b_59_199", 32'd59, 32'd199, 1, 24'h15688E, 3'd0);
    pix_check("b_59_200", 32'd59, 32'd200, 0, BG,         3'd0);

    write_wall(1, 32'd0, 32'd100, 32'd0, 32'd100, 24'hFF0000, 1);
    commit();
    pix_check("ovl_30_40", 32'd30, 32'd40, 1, 24'h15688E, 3'd0);
    pix_check("ovl_10_10", 32'd10, 32'd10, 1, 24'hFF0000, 3'd1);
    wr(0, 5, 32'd0);
    commit();
    pix_check("w0_off", 32'd30, 32'd40, 1, 24'hFF0000, 3'd1);
    wr(0, 5, 32'd1);
    commit();

    wr(0, 4, 32'h0000FF00, 1);
    pix_check("same_cycle_old", 32'd30, 32'd40, 1, 24'h15688E, 3'd0);
    commit();
    pix_check("same_cycle_new", 32'd30, 32'd40, 1, 24'h00FF00, 3'd0);

    wr(N, 4, 32'h00ABCDEF);
    wr(N, 0, 32'd0);
    wr(N, 5, 32'd1);
    wr(0, 7, 32'hFFFFFFFF);
    wr(0, 6, 32'd0);
    commit();
    pix_check("ignored_w0", 32'd30, 32'd40, 1, 24'h00FF00, 3'd0);
    pix_check("ignored_w1", 32'd10, 32'd10, 1, 24'hFF0000, 3'd1);
    pix_check("ignored_miss", 32'd150, 32'd150, 0, BG, 3'd0);

    // Stream hits, then reset mid-stream: outputs drop immediately and the
    // walls are gone afterwards.
    repeat (4) cycle(0, 6'd0, 32'd0, 0, 1, 32'd30, 32'd40);
    do_reset();
    pix_check("after_rst", 32'd30, 32'd40, 0, BG, 3'd0);

    write_wall(0, 32'd20, 32'd90, 32'd20, 32'd90, 24'h123456, 1);
    write_wall(1, 32'd0, 32'd64, 32'd0, 32'd128, 24'hFF0000, 1);
    write_wall(2, 32'd50, 32'd50, 32'd0, 32'd1000, 24'hDEAD00, 1);
    write_wall(3, 32'd60, 32'd128, 32'd60, 32'd128, 24'h00BEEF, 1);
    write_wall(4, 32'd100, 32'd40, 32'd0, 32'd128, 24'h777777, 1);
    commit();
    for (int i = 0; i < 1000; i++) begin
      int unsigned r;
      int widx;
      bit [31:0] d;
      r = $urandom_range(0, 99);
      if (r < 10) begin
        widx = $urandom_range(0, 6);
        if (widx >= 2) widx++;
        d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
        cycle(1, {3'(widx), 3'($urandom_range(0, 7))}, d,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
              32'($urandom_range(0, 127)), 32'($urandom_range(0, 127)));
      end else begin
        cycle(0, 6'd0, 32'd0, (r < 13), (r < 85),
              (r == 84) ? $urandom : 32'($urandom_range(0, 127)),
              32'($urandom_range(0, 127)));
      end
    end
    idle();
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
